// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   NUM_REQ : number of requesters sharing the mux
//   SEL_W   : width of the mux select / requester index
//   state_t : scheduler FSM state encoding
//   onehot  : index -> one-hot grant vector
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, bit i = requester i
//   ptr : index that has first priority
//   any : at least one request is set
//   idx : first set request scanning ptr, ptr+1, ... (mod NUM_REQ)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the lowest priority back to the highest so the last hit wins,
  // which avoids a separate "found" flag.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving a shared 4:1 mux.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : level request per requester (bit0=a .. bit3=d)
//   a..d  : requester data
//   gnt   : registered one-hot grant, 0 when idle
//   sel   : registered index of current owner (holds last value when idle)
//   valid : a grant is active
//   out   : data of requester sel while valid, else 0
//
// state | meaning
// IDLE  | no owner, gnt = 0, waiting for any request
// BUSY  | one owner holds the mux, cnt = cycles held minus one
module mux_rr_scheduler
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic [WIDTH-1:0]   out
);

  localparam int              CNT_W    = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= BUSY;
            gnt   <= onehot(pick_idx);
            sel   <= pick_idx;
            ptr   <= pick_idx + 1'b1;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (req[sel] && (cnt < CNT_LAST)) begin
            cnt <= cnt + 1'b1;
          end else if (pick_any) begin
            // ptr already points past the owner, so a sole requester at
            // hold expiry is simply picked again.
            gnt <= onehot(pick_idx);
            sel <= pick_idx;
            ptr <= pick_idx + 1'b1;
            cnt <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign valid = |gnt;

  always_comb begin
    out = '0;
    if (valid) begin
      case (sel)
        2'd0:    out = a;
        2'd1:    out = b;
        2'd2:    out = c;
        default: out = d;
      endcase
    end
  end

endmodule
